// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath defaults, twiddle unity constant and {re,im} pack helpers
package fft_pkg;
  localparam int DW_DEF = 12;
  localparam int TW_DEF = 12;
  localparam int TAGW_DEF = 8;
  localparam int TW_ONE = 2 ** (TW_DEF - 1) - 1;
  typedef logic signed [DW_DEF-1:0] comp_t;
  function automatic logic [2*DW_DEF-1:0] pack_c(input comp_t re, input comp_t im);
    return {re, im};
  endfunction
  function automatic comp_t re_of(input logic [2*DW_DEF-1:0] v);
    return v[2*DW_DEF-1:DW_DEF];
  endfunction
  function automatic comp_t im_of(input logic [2*DW_DEF-1:0] v);
    return v[DW_DEF-1:0];
  endfunction
endpackage

// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: two-stage B*W complex multiply with Q1.(TW-1) rescale; BFLY_ROUND_EN selects round half-up
module cmplx_mult_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              en,
  input  logic              in_valid,
  input  logic [2*DW-1:0]   in_b,
  input  logic [2*TW-1:0]   in_w,
  output logic              out_valid,
  output logic [2*DW+3:0]   out_bw
);
  localparam int PW = DW + TW;
`ifdef BFLY_ROUND_EN
  localparam logic signed [PW:0] RND = (PW+1)'(2 ** (TW - 2));
`else
  localparam logic signed [PW:0] RND = '0;
`endif
  logic signed [DW-1:0] br, bi;
  logic signed [TW-1:0] wr, wi;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0] sr, si;
  logic v1;
  assign br = in_b[2*DW-1:DW];
  assign bi = in_b[DW-1:0];
  assign wr = in_w[2*TW-1:TW];
  assign wi = in_w[TW-1:0];
  assign sr = $signed({p_rr[PW-1], p_rr}) - $signed({p_ii[PW-1], p_ii}) + RND;
  assign si = $signed({p_ri[PW-1], p_ri}) + $signed({p_ir[PW-1], p_ir}) + RND;
  // dropping the low TW-1 bits is the floor shift; the top DW+2 bits hold the full range
  always_ff @(posedge clk) begin
    if (reset_p) begin
      v1 <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      out_valid <= 1'b0;
      out_bw <= '0;
    end else if (en) begin
      v1 <= in_valid;
      p_rr <= PW'(br) * PW'(wr);
      p_ii <= PW'(bi) * PW'(wi);
      p_ri <= PW'(br) * PW'(wi);
      p_ir <= PW'(bi) * PW'(wr);
      out_valid <= v1;
      out_bw <= {sr[PW:TW-1], si[PW:TW-1]};
    end
  end
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly X0=A+WB, X1=A-WB with scale, saturation, sticky ovf
// BFLY_ROUND_EN: round half-up on both right shifts instead of floor
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_a,
  input  logic [2*DW-1:0] in_b,
  input  logic [2*TW-1:0] in_w,
  input  logic            in_scale,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_x0,
  output logic [2*DW-1:0] out_x1,
  output logic [TAGW-1:0] out_tag,
  output logic            ovf,
  input  logic            ovf_clr
);
  localparam int BW = DW + 2;
  localparam logic signed [DW+2:0] SMAX = (DW+3)'(2 ** (DW - 1) - 1);
  localparam logic signed [DW+2:0] SMIN = -(DW+3)'(2 ** (DW - 1));
`ifdef BFLY_ROUND_EN
  localparam logic signed [DW+2:0] RND1 = (DW+3)'(1);
`else
  localparam logic signed [DW+2:0] RND1 = '0;
`endif
  logic en, v2, sc1, sc2, ovf_set;
  logic [2*BW-1:0] bw;
  logic [2*DW-1:0] a1, a2;
  logic [TAGW-1:0] t1, t2;
  logic signed [DW+2:0] ar, ai, bwr, bwi;
  logic [DW:0] f0r, f0i, f1r, f1i;
  // returns {saturated, value}
  function automatic logic [DW:0] fin(input logic signed [DW+2:0] s, input logic sc);
    logic signed [DW+2:0] y;
    y = sc ? (s + RND1) >>> 1 : s;
    return y > SMAX ? {1'b1, SMAX[DW-1:0]} : y < SMIN ? {1'b1, SMIN[DW-1:0]} : {1'b0, y[DW-1:0]};
  endfunction
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  cmplx_mult_pipe #(.DW(DW), .TW(TW)) u_mult (
    .clk(clk),
    .reset_p(reset_p),
    .en(en),
    .in_valid(in_valid),
    .in_b(in_b),
    .in_w(in_w),
    .out_valid(v2),
    .out_bw(bw)
  );
  assign ar = $signed({{3{a2[2*DW-1]}}, a2[2*DW-1:DW]});
  assign ai = $signed({{3{a2[DW-1]}}, a2[DW-1:0]});
  assign bwr = $signed({bw[2*BW-1], bw[2*BW-1:BW]});
  assign bwi = $signed({bw[BW-1], bw[BW-1:0]});
  assign f0r = fin(ar + bwr, sc2);
  assign f0i = fin(ai + bwi, sc2);
  assign f1r = fin(ar - bwr, sc2);
  assign f1i = fin(ai - bwi, sc2);
  assign ovf_set = en & v2 & (f0r[DW] | f0i[DW] | f1r[DW] | f1i[DW]);
  always_ff @(posedge clk) begin
    if (reset_p) begin
      a1 <= '0;
      a2 <= '0;
      sc1 <= 1'b0;
      sc2 <= 1'b0;
      t1 <= '0;
      t2 <= '0;
      out_valid <= 1'b0;
      out_x0 <= '0;
      out_x1 <= '0;
      out_tag <= '0;
      ovf <= 1'b0;
    end else begin
      if (en) begin
        a1 <= in_a;
        a2 <= a1;
        sc1 <= in_scale;
        sc2 <= sc1;
        t1 <= in_tag;
        t2 <= t1;
        out_valid <= v2;
        out_x0 <= {f0r[DW-1:0], f0i[DW-1:0]};
        out_x1 <= {f1r[DW-1:0], f1i[DW-1:0]};
        out_tag <= t2;
      end
      ovf <= ovf_set | (ovf & !ovf_clr);
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed and random self-checking bench for butterfly_pipe (honours BFLY_ROUND_EN)
module tb_butterfly_pipe;
  import fft_pkg::*;
`ifdef BFLY_ROUND_EN
  localparam int RND = 1024;
  localparam int R1 = 1;
  localparam int T1X0 = 75;
`else
  localparam int RND = 0;
  localparam int R1 = 0;
  localparam int T1X0 = 74;
`endif
  logic clk = 1'b0;
  logic reset_p, in_valid, in_ready, in_scale, out_valid, out_ready, ovf, ovf_clr;
  logic [23:0] in_a, in_b, in_w, out_x0, out_x1;
  logic [7:0] in_tag, out_tag;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  butterfly_pipe dut (
    .clk(clk), .reset_p(reset_p), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_scale(in_scale), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_x0(out_x0), .out_x1(out_x1),
    .out_tag(out_tag), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  function automatic logic [23:0] pk(input int re, input int im);
    return pack_c(comp_t'(re), comp_t'(im));
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  task automatic drive(input int ar, ai, br, bi, wr, wi, input bit sc, input int tg);
    in_a = pk(ar, ai);
    in_b = pk(br, bi);
    in_w = pk(wr, wi);
    in_scale = sc;
    in_tag = 8'(tg);
    in_valid = 1'b1;
  endtask
  function automatic int clamp(input int v, inout bit s);
    int c;
    c = v > 2047 ? 2047 : v < -2048 ? -2048 : v;
    s |= (c != v);
    return c;
  endfunction
  function automatic int fix(input int v, input bit sc, inout bit s);
    return clamp(sc ? (v + R1) >>> 1 : v, s);
  endfunction
  task automatic model(input int ar, ai, br, bi, wr, wi, input bit sc,
                       output logic [23:0] x0, x1, output bit s);
    int bwr, bwi;
    s = 0;
    bwr = (br * wr - bi * wi + RND) >>> 11;
    bwi = (br * wi + bi * wr + RND) >>> 11;
    x0 = pk(fix(ar + bwr, sc, s), fix(ai + bwi, sc, s));
    x1 = pk(fix(ar - bwr, sc, s), fix(ai - bwi, sc, s));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [23:0] e0, e1;
    logic [55:0] q[$];
    logic [55:0] e;
    bit s, ovf_exp;
    int ar, ai, br, bi, wr, wi, outs;
    bit sc;
    reset_p = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_w = '0;
    in_scale = 1'b0;
    in_tag = '0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", {out_x0, out_x1, out_tag}, 0);
    reset_p = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    // scaled real butterfly; latency exactly three edges from acceptance
    drive(100, 0, 50, 0, TW_ONE, 0, 1'b1, 8'h11);
    step();
    in_valid = 1'b0;
    chk("t1_lat_a", out_valid, 0);
    step();
    chk("t1_lat_b", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_x0", out_x0, pk(T1X0, 0));
    chk("t1_x1", out_x1, pk(25, 0));
    chk("t1_tag", out_tag, 8'h11);
    // multiply by -j
    drive(0, 0, 50, 30, 0, -2048, 1'b0, 8'h22);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t2_valid", out_valid, 1);
    chk("t2_x0", out_x0, pk(30, -50));
    chk("t2_x1", out_x1, pk(-30, 50));
    chk("t2_ovf", ovf, 0);
    // positive saturation and sticky overflow
    drive(2047, 0, 2047, 0, TW_ONE, 0, 1'b0, 8'h33);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t3_x0", out_x0, pk(2047, 0));
    chk("t3_x1", out_x1, pk(1, 0));
    chk("t3_ovf", ovf, 1);
    step();
    chk("t3_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", ovf, 0);
    // back-pressure: three beats, hold downstream for five cycles
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive(10 * t, -t, 0, 0, 0, 0, 1'b0, t);
      step();
    end
    in_valid = 1'b0;
    chk("t4_in_ready", in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold", {out_valid, out_x0, out_x1, out_tag}, {1'b1, pk(10, -1), pk(10, -1), 8'd1});
      chk("t4_in_ready_hold", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    for (int t = 2; t <= 3; t++) begin
      step();
      chk("t4_order", {out_valid, out_x0, out_x1, out_tag}, {1'b1, pk(10 * t, -t), pk(10 * t, -t), 8'(t)});
    end
    step();
    chk("t4_drain", out_valid, 0);
    // continuous random stream against reference model
    outs = 0;
    ovf_exp = 0;
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin
        ar = int'($urandom_range(0, 4095)) - 2048;
        ai = int'($urandom_range(0, 4095)) - 2048;
        br = int'($urandom_range(0, 4095)) - 2048;
        bi = int'($urandom_range(0, 4095)) - 2048;
        wr = int'($urandom_range(0, 4095)) - 2048;
        wi = int'($urandom_range(0, 4095)) - 2048;
        sc = 1'($urandom_range(0, 1));
        drive(ar, ai, br, bi, wr, wi, sc, i);
        model(ar, ai, br, bi, wr, wi, sc, e0, e1, s);
        q.push_back({e0, e1, 8'(i)});
        ovf_exp |= s;
      end else in_valid = 1'b0;
      step();
      if (out_valid) begin
        outs++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rnd_beat", {out_x0, out_x1, out_tag}, e);
        end else chk("rnd_extra", 1, 0);
      end
    end
    chk("rnd_throughput", outs, 64);
    chk("rnd_ovf", ovf, ovf_exp);
    // mid-stream reset flushes in-flight beats
    step();
    drive(1, 1, 0, 0, 0, 0, 1'b0, 8'hA0);
    step();
    drive(2, 2, 0, 0, 0, 0, 1'b0, 8'hB0);
    step();
    in_valid = 1'b0;
    reset_p = 1'b1;
    step();
    reset_p = 1'b0;
    chk("t6_flush_valid", out_valid, 0);
    chk("t6_flush_ovf", ovf, 0);
    chk("t6_in_ready", in_ready, 1);
    drive(5, 6, 0, 0, 0, 0, 1'b0, 8'hC0);
    step();
    in_valid = 1'b0;
    chk("t6_lat_a", out_valid, 0);
    step();
    chk("t6_lat_b", out_valid, 0);
    step();
    chk("t6_beat", {out_valid, out_x0, out_tag}, {1'b1, pk(5, 6), 8'hC0});
    step();
    chk("t6_no_more", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath. Computes X0 = A + W·B and X1 = A − W·B, with a twiddle multiply, a per-sample scale select, and saturation plus a sticky overflow flag. Uses a valid/ready handshake on both sides and carries a sideband tag, so the stage controller can stream butterflies back-to-back and tolerate back-pressure.

Parameters:
DW, 12, bits per real/imag component of data (packed {re,im}, 2*DW bits)
TW, 12, bits per twiddle component, signed Q1.(TW-1); +1 is approximated by 2^(TW-1)-1
TAGW, 8, sideband tag width (butterfly index), passed through untouched

Ports:
clk  in  1  clock; all logic on rising edge
reset_p  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept the beat this cycle
in_a  in  2*DW  operand A {re[2DW-1:DW], im[DW-1:0]}, signed
in_b  in  2*DW  operand B, same packing
in_w  in  2*TW  twiddle {re, im}, signed
in_scale  in  1  1: divide result by 2; 0: no scaling
in_tag  in  TAGW  sideband tag
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_x0  out  2*DW  A + W·B, packed
out_x1  out  2*DW  A − W·B, packed
out_tag  out  TAGW  tag of this beat
ovf  out  1  sticky: set when any output component saturated
ovf_clr  in  1  clears ovf; a set in the same cycle wins

Behaviour:
- Reset (synchronous): all stage valid bits, out_valid and ovf go to 0. Data and tag registers also reset to 0. in_ready equals 1 in the cycle after reset deasserts.
- Three register stages; latency is 3 cycles from input acceptance to out_valid when there is no stall.
  - S1 registers A, W, scale, tag, and the four partial products br*wr, bi*wi, br*wi, bi*wr (each DW+TW bits).
  - S2 forms BWr = br*wr − bi*wi and BWi = br*wi + bi*wr at DW+TW+1 bits, then shifts arithmetically right by TW-1 (floor) and keeps DW+2 bits.
  - S3 computes A ± BW at DW+3 bits. If scale=1, shifts right by 1 (floor). Saturates each component to [−2^(DW-1), 2^(DW-1)−1] and registers the outputs.
- No internal wrap is allowed anywhere; all intermediate widths are sized to the full range.
- Advance enable: en = !out_valid | out_ready. When en=1, all stages shift together. When en=0, every stage holds. in_ready = en, so it is combinational from out_ready.
- Bubbles are not compressed; a stage's valid bit shifts along with its data.
- An input beat is accepted only on in_valid & in_ready. An output beat is consumed only on out_valid & out_ready. Order is strictly preserved and no beat is lost or duplicated under any stall pattern.
- While out_valid=1 and out_ready=0, out_x0, out_x1 and out_tag are held stable.
- ovf is set in the cycle a saturated result is registered into S3, whether or not it is consumed.
- reset_p asserted mid-stream flushes all in-flight beats; nothing is emitted for them.

Optional Feature:
- Macro BFLY_ROUND_EN.
- Defined: both right shifts round half-up (add 2^(TW-2) before the twiddle shift; add 1 before the scale shift). The addition is folded into the existing stage, so latency is unchanged.
- Undefined: both shifts truncate toward −inf (floor).

Decomposition:
- Shared package fft_pkg: default DW/TW/TAGW constants, the twiddle "+1" constant (2^(TW-1)−1), and pack/unpack helpers for {re,im}.
- One sub-module: cmplx_mult_pipe. It contains S1–S2 (B·W with shift/round), with a per-stage enable input and a valid input and output.
- Add/sub, scale and saturation stay in butterfly_pipe.

Test Plan:
- DW=TW=12, scale=1, A=(100,0), B=(50,0), W=(2047,0) -> x0=(74,0), x1=(25,0) after 3 cycles. With BFLY_ROUND_EN: x0=(75,0), x1=(25,0).
- scale=0, A=(0,0), B=(50,30), W=(0,−2048) i.e. −j -> x0=(30,−50), x1=(−30,50).
- scale=0, A=(2047,0), B=(2047,0), W=(2047,0) -> x0=(2047,0) saturated with ovf=1, x1=(1,0). Then pulse ovf_clr -> ovf=0.
- Stream 3 beats with tags 1,2,3 and hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable. Release -> tags emerge 1,2,3 with correct data and no gaps or duplicates.
- Continuous in_valid and out_ready for 64 random beats -> 1 beat/cycle throughput; results match a bit-exact reference model in both macro settings.
- Assert reset_p for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, the flushed beats are never emitted, and the next accepted beat appears 3 cycles after acceptance.
